// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: write-back source encodings, load funct3
// values and the write-back stage state type.
package riscv_pkg;

    // Write-back source select
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    // Load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        WAIT_LOAD = 2'b01,
        WRITE     = 2'b10
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment and legality check.
//   RDATA  : word-aligned data from data memory
//   TYPE   : load funct3
//   OFFSET : byte offset within the word (address bits [1:0])
//   DATA   : selected byte/half/word, sign- or zero-extended
//   ERR    : misaligned access or unsupported funct3
// Also used by the memory stage to suppress requests for bad loads, so ERR
// must not depend on RDATA.
module load_align
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [2:0]            TYPE,
    input  logic [1:0]            OFFSET,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic                  ERR
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (OFFSET)
            2'd0:    byte_sel = RDATA[7:0];
            2'd1:    byte_sel = RDATA[15:8];
            2'd2:    byte_sel = RDATA[23:16];
            default: byte_sel = RDATA[31:24];
        endcase
        half_sel = OFFSET[1] ? RDATA[31:16] : RDATA[15:0];
    end

    always_comb begin
        DATA = '0;
        ERR  = 1'b0;
        case (TYPE)
            F3_LB:  DATA = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU: DATA = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH: begin
                DATA = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                ERR  = OFFSET[0];
            end
            F3_LHU: begin
                DATA = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                ERR  = OFFSET[0];
            end
            F3_LW: begin
                DATA = RDATA;
                ERR  = (OFFSET != 2'd0);
            end
            default: ERR = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: accepts retiring instructions, waits for load data,
// aligns it and drives the register file write port.
//   IN_*           : instruction from the memory stage (valid/ready)
//   DMEM_RVALID/RDATA : load response, single-cycle pulse
//   WEN/RD_SEL/WB_DATA : register file write port; RD_SEL and WB_DATA are
//                    forced to 0 when not writing so the register file
//                    bypass never matches a stale destination
//   RETIRE/LOAD_EXC : per-instruction completion pulses
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [ADDR_WIDTH-1:0] IN_RD_SEL,
    input  logic                  IN_REG_WEN,
    input  logic [1:0]            IN_WB_SEL,
    input  logic [DATA_WIDTH-1:0] IN_ALU_RESULT,
    input  logic [DATA_WIDTH-1:0] IN_PC_PLUS4,
    input  logic [DATA_WIDTH-1:0] IN_IMM,
    input  logic [2:0]            IN_LOAD_TYPE,
    input  logic                  DMEM_RVALID,
    input  logic [DATA_WIDTH-1:0] DMEM_RDATA,
    output logic                  WEN,
    output logic [ADDR_WIDTH-1:0] RD_SEL,
    output logic [DATA_WIDTH-1:0] WB_DATA,
    output logic                  RETIRE,
    output logic                  LOAD_EXC
);

    wb_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  reg_wen_q, reg_wen_d;
    logic                  exc_q, exc_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            ltype_q, ltype_d;
    logic [1:0]            off_q, off_d;

    logic                  accept;
    logic                  waiting;
    logic [DATA_WIDTH-1:0] al_data;
    logic                  al_err;

    assign waiting  = (state_q == WAIT_LOAD);
    assign IN_READY = !waiting;
    assign accept   = IN_VALID && IN_READY;

    // One aligner serves both jobs: while waiting it aligns the returning
    // data with the captured type/offset; otherwise it checks legality of
    // the incoming load (its DATA output is unused then).
    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .RDATA  (DMEM_RDATA),
        .TYPE   (waiting ? ltype_q : IN_LOAD_TYPE),
        .OFFSET (waiting ? off_q : IN_ALU_RESULT[1:0]),
        .DATA   (al_data),
        .ERR    (al_err)
    );

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        reg_wen_d = reg_wen_q;
        exc_d     = exc_q;
        data_d    = data_q;
        ltype_d   = ltype_q;
        off_d     = off_q;
        case (state_q)
            WAIT_LOAD: begin
                if (DMEM_RVALID) begin
                    data_d  = al_data;
                    state_d = WRITE;
                end
            end
            default: begin
                if (accept) begin
                    rd_d      = IN_RD_SEL;
                    reg_wen_d = IN_REG_WEN;
                    exc_d     = 1'b0;
                    state_d   = WRITE;
                    case (IN_WB_SEL)
                        WB_LOAD: begin
                            if (al_err) begin
                                // Bad load retires immediately, never writes
                                exc_d  = 1'b1;
                                data_d = '0;
                            end else begin
                                ltype_d = IN_LOAD_TYPE;
                                off_d   = IN_ALU_RESULT[1:0];
                                state_d = WAIT_LOAD;
                            end
                        end
                        WB_PC4:  data_d = IN_PC_PLUS4;
                        WB_IMM:  data_d = IN_IMM;
                        default: data_d = IN_ALU_RESULT;
                    endcase
                end else begin
                    state_d = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= EMPTY;
            rd_q      <= '0;
            reg_wen_q <= 1'b0;
            exc_q     <= 1'b0;
            data_q    <= '0;
            ltype_q   <= '0;
            off_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            reg_wen_q <= reg_wen_d;
            exc_q     <= exc_d;
            data_q    <= data_d;
            ltype_q   <= ltype_d;
            off_q     <= off_d;
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously
    assign RETIRE   = (state_q == WRITE);
    assign LOAD_EXC = RETIRE && exc_q;
    assign WEN      = RETIRE && reg_wen_q && (rd_q != '0) && !exc_q;
    assign RD_SEL   = WEN ? rd_q : '0;
    assign WB_DATA  = WEN ? data_q : '0;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [4:0]  IN_RD_SEL = '0;
    logic        IN_REG_WEN = 1'b0;
    logic [1:0]  IN_WB_SEL = '0;
    logic [31:0] IN_ALU_RESULT = '0;
    logic [31:0] IN_PC_PLUS4 = '0;
    logic [31:0] IN_IMM = '0;
    logic [2:0]  IN_LOAD_TYPE = '0;
    logic        DMEM_RVALID = 1'b0;
    logic [31:0] DMEM_RDATA = '0;
    logic        WEN;
    logic [4:0]  RD_SEL;
    logic [31:0] WB_DATA;
    logic        RETIRE;
    logic        LOAD_EXC;

    writeback_stage dut (
        .CLK(CLK), .RESETN(RESETN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_RD_SEL(IN_RD_SEL), .IN_REG_WEN(IN_REG_WEN), .IN_WB_SEL(IN_WB_SEL),
        .IN_ALU_RESULT(IN_ALU_RESULT), .IN_PC_PLUS4(IN_PC_PLUS4), .IN_IMM(IN_IMM),
        .IN_LOAD_TYPE(IN_LOAD_TYPE),
        .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
        .WEN(WEN), .RD_SEL(RD_SEL), .WB_DATA(WB_DATA),
        .RETIRE(RETIRE), .LOAD_EXC(LOAD_EXC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: what the register file must see for one instruction
    function automatic exp_t model(input logic [4:0] rd, input logic wen,
                                   input logic [1:0] sel, input logic [31:0] alu,
                                   input logic [31:0] pc4, input logic [31:0] imm,
                                   input logic [2:0] lt, input logic [31:0] rdata);
        exp_t        e;
        logic [31:0] d = 32'h0;
        logic        ex = 1'b0;
        logic [7:0]  b = 8'(rdata >> (8 * alu[1:0]));
        logic [15:0] h = 16'(rdata >> (16 * alu[1]));
        case (sel)
            2'd0: d = alu;
            2'd2: d = pc4;
            2'd3: d = imm;
            default: begin
                case (lt)
                    3'd0: d = 32'($signed(b));
                    3'd4: d = {24'h0, b};
                    3'd1: if (alu[0]) ex = 1'b1; else d = 32'($signed(h));
                    3'd5: if (alu[0]) ex = 1'b1; else d = {16'h0, h};
                    3'd2: if (alu[1:0] != 2'd0) ex = 1'b1; else d = rdata;
                    default: ex = 1'b1;
                endcase
            end
        endcase
        e.cyc  = 0;
        e.exc  = ex;
        e.wen  = wen && (rd != 5'd0) && !ex;
        e.rd   = e.wen ? rd : 5'd0;
        e.data = e.wen ? d : 32'h0;
        return e;
    endfunction

    // Drive one instruction (inputs change #1 after an edge) and, for a
    // legal load, hold off lat cycles before returning the data.
    task automatic issue(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [2:0] lt,
                         input logic [31:0] rdata, input int lat);
        exp_t        e;
        logic [31:0] pc4 = $urandom;
        logic [31:0] imm = $urandom;
        e = model(rd, wen, sel, alu, pc4, imm, lt, rdata);
        chk("in_ready_before_issue", {31'h0, IN_READY}, 32'h1);
        IN_VALID = 1'b1; IN_RD_SEL = rd; IN_REG_WEN = wen; IN_WB_SEL = sel;
        IN_ALU_RESULT = alu; IN_PC_PLUS4 = pc4; IN_IMM = imm; IN_LOAD_TYPE = lt;
        DMEM_RDATA = $urandom;
        if (sel == 2'd1 && !e.exc) begin
            DMEM_RVALID = 1'b0;
            @(posedge CLK); #1;
            IN_VALID = 1'b0;
            for (int i = 0; i < lat; i++) begin
                chk("in_ready_while_waiting", {31'h0, IN_READY}, 32'h0);
                DMEM_RDATA = $urandom;
                @(posedge CLK); #1;
            end
            DMEM_RVALID = 1'b1; DMEM_RDATA = rdata;
            @(posedge CLK); #1;
            DMEM_RVALID = 1'b0;
        end else begin
            DMEM_RVALID = 1'($urandom_range(1));   // must be ignored here
            @(posedge CLK); #1;
            IN_VALID = 1'b0; DMEM_RVALID = 1'b0;
        end
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Monitor: compare every cycle away from the clock edge
    always @(negedge CLK) begin
        if (RESETN) begin
            if (RETIRE) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_retire: got RETIRE=1 expected no instruction pending (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("retire_cycle", 32'(cyc), 32'(e.cyc));
                    chk("wen", {31'h0, WEN}, {31'h0, e.wen});
                    chk("rd_sel", {27'h0, RD_SEL}, {27'h0, e.rd});
                    chk("wb_data", WB_DATA, e.data);
                    chk("load_exc", {31'h0, LOAD_EXC}, {31'h0, e.exc});
                end
            end else begin
                chk("idle_outputs", {WEN, LOAD_EXC, RD_SEL, 24'h0} | WB_DATA, 32'h0);
            end
        end
    end

    initial begin
        #12;
        chk("reset_retire", {31'h0, RETIRE}, 32'h0);
        chk("reset_wen_rd_data", {WEN, LOAD_EXC, RD_SEL, 24'h0} | WB_DATA, 32'h0);
        @(negedge CLK);
        RESETN = 1'b1;
        @(posedge CLK); #1;
        chk("in_ready_after_reset", {31'h0, IN_READY}, 32'h1);

        // Directed cases
        issue(5'd5, 1'b1, 2'd0, 32'h0000_1234, 3'd0, 32'h0, 0);
        @(posedge CLK); #1;
        issue(5'd7, 1'b1, 2'd1, 32'h0000_0003, 3'd0, 32'h80FF_0011, 3);   // LB
        issue(5'd7, 1'b1, 2'd1, 32'h0000_0002, 3'd5, 32'h80FF_0011, 1);   // LHU
        issue(5'd7, 1'b1, 2'd1, 32'h0000_0001, 3'd2, 32'h80FF_0011, 0);   // LW misaligned
        issue(5'd0, 1'b1, 2'd0, 32'h0000_DEAD, 3'd0, 32'h0, 0);           // x0
        for (int r = 1; r <= 4; r++)
            issue(5'(r), 1'b1, 2'd0, 32'(r * 16'h1111), 3'd0, 32'h0, 0);
        issue(5'd9, 1'b1, 2'd1, 32'h0, 3'd3, 32'h0, 0);                   // funct3 011
        issue(5'd9, 1'b1, 2'd1, 32'h0, 3'd1, 32'h8000_9ABC, 0);           // LH, no wait
        @(posedge CLK); #1;

        // Reset while a load is pending: nothing may retire for it
        IN_VALID = 1'b1; IN_RD_SEL = 5'd12; IN_REG_WEN = 1'b1; IN_WB_SEL = 2'd1;
        IN_ALU_RESULT = 32'h0; IN_LOAD_TYPE = 3'd2;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        chk("in_ready_pending_load", {31'h0, IN_READY}, 32'h0);
        @(posedge CLK); #1;
        RESETN = 1'b0;
        #1;
        chk("async_reset_outputs", {WEN, LOAD_EXC, RETIRE, RD_SEL, 23'h0} | WB_DATA, 32'h0);
        chk("async_reset_ready", {31'h0, IN_READY}, 32'h1);
        @(negedge CLK);
        RESETN = 1'b1;
        @(posedge CLK); #1;
        DMEM_RVALID = 1'b1; DMEM_RDATA = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        DMEM_RVALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            logic [1:0] sel = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) sel = 2'd1;
            issue(5'($urandom), 1'($urandom_range(7) != 0), sel, $urandom,
                  3'($urandom), $urandom, int'($urandom_range(3)));
            repeat ($urandom_range(2) == 0 ? 1 : 0) begin
                @(posedge CLK); #1;
            end
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
